// File: rtl/uart_program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_program_loader
// Purpose  : Receive side of the debug serial link. Deserializes UART frames
//            on rx (16x oversampled by the shared baud tick), packs every
//            N_BYTES bytes big-endian into one instruction word and writes it
//            into instruction memory through the debug write port.
// Ports    : clock        - system clock
//            reset        - asynchronous, active-low reset
//            tick         - one-cycle pulse at 16x baud rate
//            rx           - serial input, idle high (2-flop synchronized)
//            load_en      - arm loader; low clears assembler and flags
//            o_data_mem   - assembled instruction (held until next strobe)
//            o_dir_wr_mem - byte address of the write
//            write_to_mem - one-cycle write strobe
//            finish_rcv   - sticky: halt word received or memory full
//            overflow     - sticky: memory filled without halt word
//            frame_error  - sticky: stop bit sampled low
//            parity_error - sticky: even-parity mismatch
// Options  : UART_LOADER_PARITY_EN - expect one even-parity bit after the
//            data bits; without it frames are 8N1 and parity_error is 0.
// Revision : 1.0 - initial release
// ============================================================================
module uart_program_loader #(
  parameter int                   NB_DATA   = 32,
  parameter int                   N_BITS    = 8,
  parameter int                   N_BYTES   = 4,
  parameter int                   NB_ADDR   = 7,
  parameter int                   SB_TICK   = 16,
  parameter logic [NB_DATA-1:0]   HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               rx,
  input  logic               load_en,
  output logic [NB_DATA-1:0] o_data_mem,
  output logic [NB_ADDR-1:0] o_dir_wr_mem,
  output logic               write_to_mem,
  output logic               finish_rcv,
  output logic               overflow,
  output logic               frame_error,
  output logic               parity_error
);

  localparam int TICK_W = $clog2(SB_TICK);
  localparam int BIT_W  = $clog2(N_BITS);
  localparam int IDX_W  = $clog2(N_BYTES);
  localparam int PART_W = NB_DATA - N_BITS;

  localparam logic [TICK_W-1:0]  TICK_MID  = TICK_W'(SB_TICK / 2 - 1);
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(N_BITS - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(N_BYTES - 1);
  localparam logic [NB_ADDR-1:0] ADDR_STEP = NB_ADDR'(N_BYTES);
  localparam logic [NB_ADDR-1:0] ADDR_LAST = NB_ADDR'((2 ** NB_ADDR) - N_BYTES);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_LOADER_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  // --------------------------------------------------------------------------
  // Input synchronizer (idle-high so reset does not look like a start bit)
  // --------------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [TICK_W-1:0] tick_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [N_BITS-1:0] shift_byte;

  logic mid_tick;
  logic bit_tick;
  assign mid_tick = tick && (tick_cnt == TICK_MID);
  assign bit_tick = tick && (tick_cnt == TICK_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!rx_sync && !finish_rcv) next_state = ST_START;
      end
      ST_START: begin
        // Line back high at mid-bit means a glitch, not a start bit.
        if (mid_tick) next_state = rx_sync ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick && (bit_cnt == BIT_LAST)) begin
`ifdef UART_LOADER_PARITY_EN
          next_state = ST_PARITY;
`else
          next_state = ST_STOP;
`endif
        end
      end
`ifdef UART_LOADER_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) next_state = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_tick) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    // Disarming aborts any frame in flight.
    if (!load_en) next_state = ST_IDLE;
  end

  // Output decode of the FSM: sampling events in the current cycle.
  logic data_sample;
  logic stop_sample;
  logic byte_valid;
  logic frame_fail;
`ifdef UART_LOADER_PARITY_EN
  logic par_sample;
  logic par_fail;
  logic par_bad;
`endif

  always_comb begin
    data_sample = (state == ST_DATA) && bit_tick;
    stop_sample = (state == ST_STOP) && bit_tick;
    frame_fail  = stop_sample && !rx_sync;
`ifdef UART_LOADER_PARITY_EN
    par_sample  = (state == ST_PARITY) && bit_tick;
    par_fail    = par_sample && (rx_sync != (^shift_byte));
    byte_valid  = stop_sample && rx_sync && !par_bad;
`else
    byte_valid  = stop_sample && rx_sync;
`endif
  end

  // Bit timing and deserializer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_byte <= '0;
`ifdef UART_LOADER_PARITY_EN
      par_bad    <= 1'b0;
`endif
    end else if (!load_en) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
`ifdef UART_LOADER_PARITY_EN
      par_bad    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
`ifdef UART_LOADER_PARITY_EN
          par_bad  <= 1'b0;
`endif
        end
        ST_START: begin
          // Restart the count at mid-bit so later samples land mid-bit too.
          if (tick) tick_cnt <= mid_tick ? '0 : tick_cnt + 1'b1;
        end
        default: begin
          if (tick) tick_cnt <= bit_tick ? '0 : tick_cnt + 1'b1;
        end
      endcase
      if (data_sample) begin
        shift_byte <= {rx_sync, shift_byte[N_BITS-1:1]};
        bit_cnt    <= bit_cnt + 1'b1;
      end
`ifdef UART_LOADER_PARITY_EN
      if (par_sample) par_bad <= par_fail;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Word assembler and memory write port
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]   byte_idx;
  logic [NB_ADDR-1:0] addr;
  logic [PART_W-1:0]  partial;
  logic [NB_DATA-1:0] full_word;

  assign full_word = {partial, shift_byte};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_idx     <= '0;
      addr         <= '0;
      partial      <= '0;
      o_data_mem   <= '0;
      o_dir_wr_mem <= '0;
      write_to_mem <= 1'b0;
      finish_rcv   <= 1'b0;
      overflow     <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      write_to_mem <= 1'b0;
      if (!load_en) begin
        // Clear takes priority over a strobe landing in the same cycle.
        byte_idx    <= '0;
        addr        <= '0;
        partial     <= '0;
        finish_rcv  <= 1'b0;
        overflow    <= 1'b0;
        frame_error <= 1'b0;
      end else begin
        if (frame_fail) frame_error <= 1'b1;
        if (byte_valid) begin
          if (byte_idx == IDX_LAST) begin
            byte_idx     <= '0;
            partial      <= '0;
            write_to_mem <= 1'b1;
            o_data_mem   <= full_word;
            o_dir_wr_mem <= addr;
            if (full_word == HALT_WORD) begin
              finish_rcv <= 1'b1;
            end else if (addr == ADDR_LAST) begin
              finish_rcv <= 1'b1;
              overflow   <= 1'b1;
            end
            // Hold at the top address instead of wrapping onto word 0.
            if (addr != ADDR_LAST) addr <= addr + ADDR_STEP;
          end else begin
            byte_idx <= byte_idx + 1'b1;
            partial  <= {partial[PART_W-N_BITS-1:0], shift_byte};
          end
        end
      end
    end
  end

`ifdef UART_LOADER_PARITY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      parity_error <= 1'b0;
    end else if (!load_en) begin
      parity_error <= 1'b0;
    end else if (par_fail) begin
      parity_error <= 1'b1;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_program_loader
// Purpose  : Directed self-checking bench for uart_program_loader. Drives
//            serial frames on rx and checks the memory write port and flags
//            against hand-computed values.
// Options  : UART_LOADER_PARITY_EN - also sends parity bits and checks the
//            parity-error path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_program_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        tick = 1'b0;
  logic        rx;
  logic        load_en;
  logic [31:0] o_data_mem;
  logic [6:0]  o_dir_wr_mem;
  logic        write_to_mem;
  logic        finish_rcv;
  logic        overflow;
  logic        frame_error;
  logic        parity_error;

  uart_program_loader dut (
    .clock        (clock),
    .reset        (reset),
    .tick         (tick),
    .rx           (rx),
    .load_en      (load_en),
    .o_data_mem   (o_data_mem),
    .o_dir_wr_mem (o_dir_wr_mem),
    .write_to_mem (write_to_mem),
    .finish_rcv   (finish_rcv),
    .overflow     (overflow),
    .frame_error  (frame_error),
    .parity_error (parity_error)
  );

  always #5 clock = ~clock;

  // Baud tick: one pulse every tick_div clocks (tick_div = 1 keeps it high).
  int tick_div = 2;
  int tcnt     = 0;
  always @(posedge clock) begin
    if (tcnt >= tick_div - 1) begin
      tcnt <= 0;
      tick <= 1'b1;
    end else begin
      tcnt <= tcnt + 1;
      tick <= 1'b0;
    end
  end

  // Write-port monitor, sampled on the falling edge.
  int          strobe_cnt = 0;
  logic [31:0] last_data  = '0;
  logic [6:0]  last_addr  = '0;
  logic        last_fin   = 1'b0;
  logic        last_ovf   = 1'b0;
  always @(negedge clock) begin
    if (write_to_mem === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      last_data  = o_data_mem;
      last_addr  = o_dir_wr_mem;
      last_fin   = finish_rcv;
      last_ovf   = overflow;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic v, input int ticks);
    rx = v;
    wait_cyc(ticks * tick_div);
  endtask

  // Normal frame (correct parity when enabled); stop_ok=0 drives a short
  // low stop bit so the receiver samples it low.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(b[i], 16);
`ifdef UART_LOADER_PARITY_EN
    send_bit(^b, 16);
`endif
    if (stop_ok) begin
      send_bit(1'b1, 16);
    end else begin
      send_bit(1'b0, 12);
      send_bit(1'b1, 16);
    end
    send_bit(1'b1, 4);
  endtask

`ifdef UART_LOADER_PARITY_EN
  task automatic send_frame_par(input logic [7:0] b, input logic par);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(b[i], 16);
    send_bit(par, 16);
    send_bit(1'b1, 16);
    send_bit(1'b1, 4);
  endtask
`endif

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_frame(w[8*i +: 8], 1'b1);
  endtask

  task automatic rearm();
    load_en = 1'b0;
    wait_cyc(4);
    load_en = 1'b1;
    wait_cyc(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int base;

  initial begin
    reset   = 1'b0;
    rx      = 1'b1;
    load_en = 1'b0;
    wait_cyc(5);
    check_eq("rst_data",   o_data_mem,   32'h0);
    check_eq("rst_addr",   o_dir_wr_mem, 32'h0);
    check_eq("rst_wr",     write_to_mem, 32'h0);
    check_eq("rst_finish", finish_rcv,   32'h0);
    check_eq("rst_ovf",    overflow,     32'h0);
    check_eq("rst_ferr",   frame_error,  32'h0);
    check_eq("rst_perr",   parity_error, 32'h0);
    reset = 1'b1;
    wait_cyc(3);
    load_en = 1'b1;
    wait_cyc(3);

    // First word and address advance
    send_word(32'h2001_0005);
    check_eq("w0_count", strobe_cnt, 32'd1);
    check_eq("w0_data",  last_data,  32'h2001_0005);
    check_eq("w0_addr",  last_addr,  32'd0);
    send_word(32'h1122_3344);
    check_eq("w1_count", strobe_cnt, 32'd2);
    check_eq("w1_data",  last_data,  32'h1122_3344);
    check_eq("w1_addr",  last_addr,  32'd4);

    // Halt word ends the program; later frames are ignored
    rearm();
    base = strobe_cnt;
    send_word(32'h0000_0013);
    check_eq("h0_addr", last_addr, 32'd0);
    send_word(32'h0040_0093);
    check_eq("h1_addr", last_addr, 32'd4);
    send_word(32'h0010_8113);
    check_eq("h2_addr", last_addr, 32'd8);
    check_eq("h2_finish", finish_rcv, 32'd0);
    send_word(32'hFFFF_FFFF);
    check_eq("halt_addr",   last_addr, 32'd12);
    check_eq("halt_data",   last_data, 32'hFFFF_FFFF);
    check_eq("halt_finish", last_fin,  32'd1);
    check_eq("halt_ovf",    last_ovf,  32'd0);
    send_word(32'h1212_1212);
    check_eq("halt_ignore", strobe_cnt, base + 4);
    check_eq("halt_sticky", finish_rcv, 32'd1);

    // Fill memory without halt
    rearm();
    check_eq("rearm_finish", finish_rcv, 32'd0);
    tick_div = 1;
    base = strobe_cnt;
    for (int i = 0; i < 31; i++) send_word(32'h0A00_0000 + i);
    check_eq("fill31_addr",   last_addr,  32'd120);
    check_eq("fill31_finish", finish_rcv, 32'd0);
    send_word(32'h0A00_001F);
    check_eq("fill_count",  strobe_cnt, base + 32);
    check_eq("fill_addr",   last_addr,  32'd124);
    check_eq("fill_data",   last_data,  32'h0A00_001F);
    check_eq("fill_finish", last_fin,   32'd1);
    check_eq("fill_ovf",    last_ovf,   32'd1);
    tick_div = 2;
    wait_cyc(4);

    // Glitch and framing error leave the byte index alone
    rearm();
    check_eq("rearm_ovf", overflow, 32'd0);
    base = strobe_cnt;
    rx = 1'b0;
    wait_cyc(3 * tick_div);
    rx = 1'b1;
    wait_cyc(40 * tick_div);
    send_frame(8'hAB, 1'b0);
    check_eq("ferr_set",      frame_error, 32'd1);
    check_eq("ferr_nostrobe", strobe_cnt,  base);
    send_word(32'hC0DE_0042);
    check_eq("ferr_count", strobe_cnt, base + 1);
    check_eq("ferr_data",  last_data,  32'hC0DE_0042);
    check_eq("ferr_addr",  last_addr,  32'd0);
    rearm();
    check_eq("ferr_clear", frame_error, 32'd0);

    // Disarm mid-word discards the partial word
    send_frame(8'hAA, 1'b1);
    send_frame(8'hBB, 1'b1);
    rearm();
    base = strobe_cnt;
    send_word(32'h0102_0304);
    check_eq("abort_count", strobe_cnt, base + 1);
    check_eq("abort_data",  last_data,  32'h0102_0304);
    check_eq("abort_addr",  last_addr,  32'd0);

    // Asynchronous reset in the middle of a frame
    send_frame(8'h55, 1'b1);
    send_frame(8'h66, 1'b1);
    rx = 1'b0;
    wait_cyc(40);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_data", o_data_mem,   32'h0);
    check_eq("arst_addr", o_dir_wr_mem, 32'h0);
    rx = 1'b1;
    wait_cyc(4);
    reset = 1'b1;
    wait_cyc(40 * tick_div);
    send_word(32'h0BAD_F00D);
    check_eq("arst_wdata", last_data, 32'h0BAD_F00D);
    check_eq("arst_waddr", last_addr, 32'd0);

`ifdef UART_LOADER_PARITY_EN
    rearm();
    base = strobe_cnt;
    send_frame_par(8'h03, 1'b1);
    check_eq("perr_set", parity_error, 32'd1);
    send_frame_par(8'h03, 1'b0);
    send_frame(8'h04, 1'b1);
    send_frame(8'h05, 1'b1);
    send_frame(8'h06, 1'b1);
    check_eq("perr_count", strobe_cnt, base + 1);
    check_eq("perr_data",  last_data,  32'h0304_0506);
    check_eq("perr_addr",  last_addr,  32'd0);
`else
    check_eq("perr_const", parity_error, 32'd0);
`endif

    wait_cyc(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
